// File: rtl/softmax_ce_backward_block_pkg.sv
// Shared training constants and defaults for the softmax+cross-entropy backward block.
package softmax_ce_backward_block_pkg;

  localparam int unsigned CHAR_NUM = 192;
  localparam int unsigned CHAR_LOG = 8;
  localparam int unsigned N_LEN    = 16;
  localparam int unsigned N_LEN_W  = 8;
  localparam int unsigned F_LEN    = 8;
  localparam int unsigned F_LEN_W  = 6;
  localparam int unsigned DATA_N_DEFAULT = 8;

endpackage

// File: rtl/softmax_ce_backward_block_sub_lane.sv
// One gradient lane: d = sat((y - onehot) >>> (F_IN-F_OUT)), purely combinational.
module softmax_ce_sub_lane #(
  parameter int unsigned N_LEN   = 16,
  parameter int unsigned N_LEN_W = 8,
  parameter int unsigned F_IN    = 8,
  parameter int unsigned F_OUT   = 6
) (
  input  logic [N_LEN-1:0]   y,
  input  logic               is_target,
  output logic [N_LEN_W-1:0] d
);

  localparam int unsigned DW = N_LEN + 1;
  localparam int unsigned SH = F_IN - F_OUT;
  localparam logic signed [DW-1:0] ONE     = DW'(1) << F_IN;
  localparam logic signed [DW-1:0] ZERO    = DW'(0);
  localparam logic signed [DW-1:0] SAT_MAX = DW'((1 << (N_LEN_W - 1)) - 1);
  localparam logic signed [DW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [DW-1:0] diff;
  logic signed [DW-1:0] sh;

  // Arithmetic shift floors toward -inf before clamping into the output range.
  always_comb begin
    diff = $signed({1'b0, y}) - (is_target ? ONE : ZERO);
    sh   = diff >>> SH;
    if (sh > SAT_MAX) begin
      d = SAT_MAX[N_LEN_W-1:0];
    end else if (sh < SAT_MIN) begin
      d = SAT_MIN[N_LEN_W-1:0];
    end else begin
      d = sh[N_LEN_W-1:0];
    end
  end

endmodule

// File: rtl/softmax_ce_backward_block.sv
// Fused softmax + cross-entropy gradient d = y - onehot(t), computed DATA_N elements per cycle.
module softmax_ce_backward_block
  import softmax_ce_backward_block_pkg::*;
#(
  parameter int unsigned DATA_N = DATA_N_DEFAULT,
  parameter int unsigned F_IN   = F_LEN,
  parameter int unsigned F_OUT  = F_LEN_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic [CHAR_NUM*N_LEN-1:0]   y,
  input  logic [CHAR_LOG-1:0]         t,
  output logic                        valid,
  output logic [CHAR_NUM*N_LEN_W-1:0] d
);

  localparam int unsigned K       = CHAR_NUM / DATA_N;
  localparam int unsigned CNT_W   = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned IDX_W   = CHAR_LOG + 1;
  localparam int unsigned CHUNK_W = DATA_N * N_LEN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

  logic [CNT_W-1:0]   cnt;
  logic [CHUNK_W-1:0] y_chunk_c;
  logic [N_LEN_W-1:0] lane_d_c [DATA_N];

  logic               s1_vld;
  logic [CNT_W-1:0]   s1_idx;
  logic [N_LEN_W-1:0] s1_d [DATA_N];
  logic               wr_last;
  logic               done;
  logic [N_LEN_W-1:0] d_buf [CHAR_NUM];

  assign y_chunk_c = y[int'(cnt)*CHUNK_W +: CHUNK_W];

  for (genvar j = 0; j < DATA_N; j++) begin : g_lane
    logic is_tgt_c;
    assign is_tgt_c = ({1'b0, t} == IDX_W'(int'(cnt) * DATA_N + j));

    softmax_ce_sub_lane #(
      .N_LEN   (N_LEN),
      .N_LEN_W (N_LEN_W),
      .F_IN    (F_IN),
      .F_OUT   (F_OUT)
    ) u_lane (
      .y         (y_chunk_c[j*N_LEN +: N_LEN]),
      .is_target (is_tgt_c),
      .d         (lane_d_c[j])
    );
  end

  // Chunk counter, S1 pipeline stage and completion tracking; run low clears the pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      s1_vld  <= 1'b0;
      s1_idx  <= '0;
      wr_last <= 1'b0;
      done    <= 1'b0;
      for (int j = 0; j < DATA_N; j++) s1_d[j] <= '0;
    end else if (!run) begin
      cnt     <= '0;
      s1_vld  <= 1'b0;
      wr_last <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (cnt != LAST) cnt <= cnt + CNT_W'(1);
      s1_vld  <= 1'b1;
      s1_idx  <= cnt;
      s1_d    <= lane_d_c;
      wr_last <= s1_vld && (s1_idx == LAST);
      done    <= done | wr_last;
    end
  end

  // S2: commit the registered lanes into the result buffer; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHAR_NUM; i++) d_buf[i] <= '0;
    end else if (s1_vld) begin
      for (int j = 0; j < DATA_N; j++) d_buf[int'(s1_idx)*DATA_N + j] <= s1_d[j];
    end
  end

  for (genvar i = 0; i < CHAR_NUM; i++) begin : g_out
    assign d[i*N_LEN_W +: N_LEN_W] = d_buf[i];
  end

  assign valid = run & done;

endmodule
